decode_writeback: RTL and testbench

- Y86-64 decode/write-back stage; sits directly downstream of the fetch stage and consumes its icode/ifun/rA/rB/valC/valP.
- Holds the 15-entry 64-bit program register file and derives srcA/srcB/dstE/dstM from icode.
- Reads operands with write-back bypass and registers all results into the decode-to-execute pipeline register.
- Supports stall/bubble control from the hazard unit.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/regfile_15x64.sv | 74 +++++++
 rtl/decode_writeback.sv | 138 +++++++++++++
 tb/tb_decode_writeback.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs and the
// contents of a pipeline bubble.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  localparam logic [3:0] BUBBLE_ICODE = INOP;
  localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

endpackage

// File: rtl/regfile_15x64.sv
// Y86-64 program register file: two bypassed read ports, E and M write
// ports (M wins on collision) and an unbypassed debug read port.
module regfile_15x64 #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [3:0]        wr_addr_e,
  input  logic [DATA_W-1:0] wr_data_e,
  input  logic [3:0]        wr_addr_m,
  input  logic [DATA_W-1:0] wr_data_m,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [0:14];

  // M is written after E so that a shared destination ends up holding valM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr_addr_e != RNONE) begin
        regs[wr_addr_e] <= wr_data_e;
      end
      if (wr_addr_m != RNONE) begin
        regs[wr_addr_m] <= wr_data_m;
      end
    end
  end

  always_comb begin
    rd_data_a = {DATA_W{1'b0}};
    if (rd_addr_a == RNONE) begin
      rd_data_a = {DATA_W{1'b0}};
    end else if (rd_addr_a == wr_addr_m) begin
      rd_data_a = wr_data_m;
    end else if (rd_addr_a == wr_addr_e) begin
      rd_data_a = wr_data_e;
    end else begin
      rd_data_a = regs[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = {DATA_W{1'b0}};
    if (rd_addr_b == RNONE) begin
      rd_data_b = {DATA_W{1'b0}};
    end else if (rd_addr_b == wr_addr_m) begin
      rd_data_b = wr_data_m;
    end else if (rd_addr_b == wr_addr_e) begin
      rd_data_b = wr_data_e;
    end else begin
      rd_data_b = regs[rd_addr_b];
    end
  end

  always_comb begin
    dbg_data = {DATA_W{1'b0}};
    if (dbg_addr == RNONE) begin
      dbg_data = {DATA_W{1'b0}};
    end else begin
      dbg_data = regs[dbg_addr];
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode / write-back stage: derives register IDs from icode, reads
// operands with write-back bypass and loads the decode-to-execute register.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RSP_ID = REG_RSP,
  parameter logic [3:0] RNONE  = REG_NONE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [DATA_W-1:0] f_valC,
  input  logic [DATA_W-1:0] f_valP,
  input  logic              f_valid,
  input  logic              stall,
  input  logic              bubble,
  input  logic [3:0]        w_dstE,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [3:0]        w_dstM,
  input  logic [DATA_W-1:0] w_valM,
  output logic [3:0]        d_icode,
  output logic [3:0]        d_ifun,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB,
  output logic [DATA_W-1:0] d_valC,
  output logic [DATA_W-1:0] d_valP,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM,
  output logic              d_valid,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] val_a;

  // Unknown icodes keep every ID at RNONE; execute flags them.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (f_icode)
      IRRMOVQ: begin src_a = f_rA;   dst_e = f_rB; end
      IIRMOVQ: begin dst_e = f_rB; end
      IRMMOVQ: begin src_a = f_rA;   src_b = f_rB; end
      IMRMOVQ: begin src_b = f_rB;   dst_m = f_rA; end
      IOPQ:    begin src_a = f_rA;   src_b = f_rB;   dst_e = f_rB; end
      ICALL:   begin src_b = RSP_ID; dst_e = RSP_ID; end
      IRET:    begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; end
      IPUSHQ:  begin src_a = f_rA;   src_b = RSP_ID; dst_e = RSP_ID; end
      IPOPQ:   begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; dst_m = f_rA; end
      default: begin src_a = RNONE; end
    endcase
  end

  regfile_15x64 #(
    .DATA_W (DATA_W),
    .RNONE  (RNONE)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (src_a),
    .rd_data_a (rd_a),
    .rd_addr_b (src_b),
    .rd_data_b (rd_b),
    .wr_addr_e (w_dstE),
    .wr_data_e (w_valE),
    .wr_addr_m (w_dstM),
    .wr_data_m (w_valM),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  // jXX and call carry the fall-through PC in valA.
  always_comb begin
    val_a = rd_a;
    if (f_icode == IJXX || f_icode == ICALL) begin
      val_a = f_valP;
    end else begin
      val_a = rd_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_icode <= BUBBLE_ICODE;
      d_ifun  <= BUBBLE_IFUN;
      d_valA  <= {DATA_W{1'b0}};
      d_valB  <= {DATA_W{1'b0}};
      d_valC  <= {DATA_W{1'b0}};
      d_valP  <= {DATA_W{1'b0}};
      d_srcA  <= RNONE;
      d_srcB  <= RNONE;
      d_dstE  <= RNONE;
      d_dstM  <= RNONE;
      d_valid <= 1'b0;
    end else if (!stall) begin
      if (bubble || !f_valid) begin
        d_icode <= BUBBLE_ICODE;
        d_ifun  <= BUBBLE_IFUN;
        d_valA  <= {DATA_W{1'b0}};
        d_valB  <= {DATA_W{1'b0}};
        d_valC  <= {DATA_W{1'b0}};
        d_valP  <= {DATA_W{1'b0}};
        d_srcA  <= RNONE;
        d_srcB  <= RNONE;
        d_dstE  <= RNONE;
        d_dstM  <= RNONE;
        d_valid <= 1'b0;
      end else begin
        d_icode <= f_icode;
        d_ifun  <= f_ifun;
        d_valA  <= val_a;
        d_valB  <= rd_b;
        d_valC  <= f_valC;
        d_valP  <= f_valP;
        d_srcA  <= src_a;
        d_srcB  <= src_b;
        d_dstE  <= dst_e;
        d_dstM  <= dst_m;
        d_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed scenarios followed by random traffic,
// checked against an array-based model of the register file and D/E register.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        f_valid, stall, bubble;
  logic [3:0]  w_dstE, w_dstM;
  logic [63:0] w_valE, w_valM;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB, d_valC, d_valP;
  logic        d_valid;
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;

  logic [63:0] rf [0:14];
  logic [3:0]  e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
  logic [63:0] e_valA, e_valB, e_valC, e_valP;
  logic        e_valid;

  int compared = 0;
  int mismatched = 0;

  decode_writeback dut (
    .clk(clk), .rst(rst),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_valid(f_valid),
    .stall(stall), .bubble(bubble),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_valA(d_valA), .d_valB(d_valB),
    .d_valC(d_valC), .d_valP(d_valP), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_valid(d_valid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [3:0] r);
    return (r == 4'hF) ? 64'h0 : rf[r];
  endfunction

  task automatic m_bubble();
    e_icode = 4'h1; e_ifun = 4'h0;
    e_valA = 64'h0; e_valB = 64'h0; e_valC = 64'h0; e_valP = 64'h0;
    e_srcA = 4'hF; e_srcB = 4'hF; e_dstE = 4'hF; e_dstM = 4'hF;
    e_valid = 1'b0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 15; i++) rf[i] = 64'h0;
    m_bubble();
  endtask

  task automatic check_all();
    chk("icode", d_icode, e_icode);
    chk("ifun", d_ifun, e_ifun);
    chk("valA", d_valA, e_valA);
    chk("valB", d_valB, e_valB);
    chk("valC", d_valC, e_valC);
    chk("valP", d_valP, e_valP);
    chk("srcA", d_srcA, e_srcA);
    chk("srcB", d_srcB, e_srcB);
    chk("dstE", d_dstE, e_dstE);
    chk("dstM", d_dstM, e_dstM);
    chk("valid", d_valid, e_valid);
    chk("dbg", dbg_data, rd(dbg_addr));
  endtask

  // A read during write-back sees exactly what the register holds after it.
  task automatic step();
    logic [3:0] ic;
    @(posedge clk);
    ic = f_icode;
    if (w_dstE != 4'hF) rf[w_dstE] = w_valE;
    if (w_dstM != 4'hF) rf[w_dstM] = w_valM;
    if (!stall) begin
      if (bubble || !f_valid) begin
        m_bubble();
      end else begin
        e_icode = ic; e_ifun = f_ifun; e_valC = f_valC; e_valP = f_valP; e_valid = 1'b1;
        e_srcA = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? f_rA :
                 (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        e_srcB = (ic inside {4'h4, 4'h5, 4'h6}) ? f_rB :
                 (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        e_dstE = (ic inside {4'h2, 4'h3, 4'h6}) ? f_rB :
                 (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        e_dstM = (ic inside {4'h5, 4'hB}) ? f_rA : 4'hF;
        e_valA = (ic inside {4'h7, 4'h8}) ? f_valP : rd(e_srcA);
        e_valB = rd(e_srcB);
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] c, input logic [63:0] p,
                       input logic v);
    f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = c; f_valP = p; f_valid = v;
  endtask

  task automatic wb(input logic [3:0] de, input logic [63:0] ve,
                    input logic [3:0] dm, input logic [63:0] vm);
    w_dstE = de; w_valE = ve; w_dstM = dm; w_valM = vm;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0; dbg_addr = 4'h0;
    drive(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    wb(4'hF, 64'h0, 4'hF, 64'h0);
    m_reset();
    #12;
    chk("rst_valid", d_valid, 1'b0);
    chk("rst_icode", d_icode, 4'h1);
    chk("rst_dstE", d_dstE, 4'hF);
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i);
      #1 chk("rst_reg", dbg_data, 64'h0);
    end
    @(negedge clk) rst = 1'b0;

    // write %rbx, then read it back through an OPq
    wb(4'h3, 64'h1234, 4'hF, 64'h0);
    step();
    @(negedge clk);
    wb(4'hF, 64'h0, 4'hF, 64'h0);
    drive(4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h22, 1'b1);
    step();
    chk("opq_valA", d_valA, 64'h1234);
    chk("opq_valB", d_valB, 64'h1234);
    chk("opq_dstE", d_dstE, 4'h3);
    chk("opq_dstM", d_dstM, 4'hF);

    // same-cycle bypass with E and M colliding on %rdx
    @(negedge clk);
    wb(4'h2, 64'h5, 4'h2, 64'h9);
    drive(4'h2, 4'h0, 4'h2, 4'h7, 64'h0, 64'h24, 1'b1);
    step();
    chk("byp_valA", d_valA, 64'h9);
    dbg_addr = 4'h2;
    #1 chk("byp_reg", dbg_data, 64'h9);

    // call with %rsp = 0x100
    @(negedge clk);
    wb(4'h4, 64'h100, 4'hF, 64'h0);
    drive(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    step();
    @(negedge clk);
    wb(4'hF, 64'h0, 4'hF, 64'h0);
    drive(4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h40, 1'b1);
    step();
    chk("call_valA", d_valA, 64'h40);
    chk("call_valB", d_valB, 64'h100);
    chk("call_srcB", d_srcB, 4'h4);
    chk("call_dstE", d_dstE, 4'h4);

    // stall wins over bubble, then bubble, then invalid fetch
    @(negedge clk);
    stall = 1'b1; bubble = 1'b1;
    drive(4'h6, 4'h1, 4'h2, 4'h3, 64'h77, 64'h50, 1'b1);
    step();
    @(negedge clk);
    drive(4'h5, 4'h0, 4'h1, 4'h4, 64'h88, 64'h5A, 1'b1);
    step();
    chk("stall_icode", d_icode, 4'h8);
    chk("stall_valA", d_valA, 64'h40);
    @(negedge clk);
    stall = 1'b0;
    step();
    chk("bub_valid", d_valid, 1'b0);
    chk("bub_icode", d_icode, 4'h1);
    @(negedge clk);
    bubble = 1'b0;
    drive(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h60, 1'b0);
    step();
    chk("inv_valid", d_valid, 1'b0);

    // asynchronous reset mid-cycle
    @(negedge clk);
    wb(4'h5, 64'hDEAD, 4'h6, 64'hBEEF);
    drive(4'h6, 4'h0, 4'h5, 4'h6, 64'h0, 64'h62, 1'b1);
    dbg_addr = 4'h5;
    step();
    @(negedge clk);
    wb(4'hF, 64'h0, 4'hF, 64'h0);
    drive(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", d_valid, 1'b0);
    chk("arst_icode", d_icode, 4'h1);
    chk("arst_dstE", d_dstE, 4'hF);
    chk("arst_valA", d_valA, 64'h0);
    m_reset();
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i);
      #1 chk("arst_reg", dbg_data, 64'h0);
    end
    @(negedge clk) rst = 1'b0;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wb(($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14)), {$urandom, $urandom},
         ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14)), {$urandom, $urandom});
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 9) == 0);
      bubble = ($urandom_range(0, 9) == 0);
      dbg_addr = 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
